// File: rtl/ps2_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_fifo
//  Purpose  : Buffered Wishbone slave for PS/2 scan codes. Queues keyboard
//             bytes in a circular FIFO and exposes a pop-on-read DATA
//             register plus a STATUS/control register via STB/ACK handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_scan_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready_pulse,
  input  logic [7:0]  Keyboard_Data,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        pending
);

  localparam logic [PTR_W:0]   c_cnt_full = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_cnt_one  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_mem [0:DEPTH-1];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [PTR_W:0]   r_cnt;
  logic             r_ovf;
  logic [31:0]      r_dat_o;

  logic             w_access;
  logic             w_data_rd;
  logic             w_stat_wr;
  logic             w_pop;
  logic             w_flush;
  logic             w_ovf_clr;
  logic             w_empty;
  logic             w_full;
  logic             w_can_push;
  logic             w_push;
  logic             w_drop;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_word;
  logic             w_unused;

  // Address bits above bit 0 and unused control bits are intentionally ignored
  assign w_unused = ^{ADDR[31:1], DAT_I[31:11], DAT_I[9:1]};

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_cnt_full);
  assign pending = !w_empty;
  assign ACK     = (r_state == S_BUSY);
  assign DAT_O   = r_dat_o;

  // An access is performed only on the IDLE->BUSY transition
  assign w_access   = (r_state == S_IDLE) && STB;
  assign w_data_rd  = w_access && !WE && !ADDR[0];
  assign w_stat_wr  = w_access &&  WE &&  ADDR[0];
  assign w_pop      = w_data_rd && !w_empty;
  assign w_flush    = w_stat_wr && DAT_I[0];
  assign w_ovf_clr  = w_stat_wr && DAT_I[10];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_can_push = !w_full || w_pop;
  assign w_push     = ready_pulse &&  w_can_push && !w_flush;
  assign w_drop     = ready_pulse && !w_can_push && !w_flush;

  // Handshake next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (STB)  w_state_nxt = S_BUSY;
      S_BUSY:  if (!STB) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status word and read-data selection, reflecting pre-edge state
  always_comb begin
    w_status            = '0;
    w_status[PTR_W:0]   = r_cnt;
    w_status[8]         = w_empty;
    w_status[9]         = w_full;
    w_status[10]        = r_ovf;

    w_rd_word = '0;
    if (!WE) begin
      if (ADDR[0]) begin
        w_rd_word = w_status;
      end else if (!w_empty) begin
        w_rd_word = {23'b0, 1'b1, r_mem[r_rp]};
      end
    end
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read data register, loaded once per accepted access
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dat_o <= '0;
    end else if (w_access) begin
      r_dat_o <= w_rd_word;
    end
  end

  // FIFO storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= Keyboard_Data;
    end
  end

  // Pointers and occupancy count; flush overrides push/pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_ptr_one;
      if (w_pop)  r_rp <= r_rp + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_one;
        2'b01:   r_cnt <= r_cnt - c_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky overflow flag; a dropped byte wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_scan_fifo
//  Purpose  : Directed self-checking bench for ps2_scan_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_fifo;

  logic        clk;
  logic        reset;
  logic        ready_pulse;
  logic [7:0]  Keyboard_Data;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        pending;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_scan_fifo #(.DEPTH(16), .PTR_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ready_pulse   (ready_pulse),
    .Keyboard_Data (Keyboard_Data),
    .STB           (STB),
    .WE            (WE),
    .ADDR          (ADDR),
    .DAT_I         (DAT_I),
    .DAT_O         (DAT_O),
    .ACK           (ACK),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    ready_pulse   = 1'b1;
    Keyboard_Data = b;
    tick();
    ready_pulse   = 1'b0;
  endtask

  // One full four-phase access; bounded wait for ACK
  task automatic wb(input logic we, input logic [31:0] addr, input logic [31:0] din,
                    output logic [31:0] dout);
    int n;
    STB   = 1'b1;
    WE    = we;
    ADDR  = addr;
    DAT_I = din;
    tick();
    n = 0;
    while (!ACK && n < 8) begin
      tick();
      n++;
    end
    if (!ACK) check("ack_timeout", {31'b0, ACK}, 32'h1);
    dout = DAT_O;
    STB  = 1'b0;
    WE   = 1'b0;
    tick();
  endtask

  logic [31:0] rd;
  int          rises;
  int          ack_lows;
  logic        prev_ack;

  initial begin
    reset = 1'b0; ready_pulse = 1'b0; Keyboard_Data = '0;
    STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;

    // Reset state
    tick(); tick();
    check("rst_ack",     {31'b0, ACK},     32'h0);
    check("rst_dato",    DAT_O,            32'h0);
    check("rst_pending", {31'b0, pending}, 32'h0);
    reset = 1'b1;
    tick();

    // Basic push / read sequence
    push(8'h1C); tick(); tick(); tick();
    push(8'hF0); tick(); tick(); tick();
    push(8'h1C);
    check("t1_pending", {31'b0, pending}, 32'h1);
    wb(1'b0, 32'h1, 32'h0, rd); check("t1_status3", rd, 32'h0000_0003);
    wb(1'b0, 32'h0, 32'h0, rd); check("t1_rd0",     rd, 32'h0000_011C);
    wb(1'b0, 32'h0, 32'h0, rd); check("t1_rd1",     rd, 32'h0000_01F0);
    wb(1'b0, 32'h0, 32'h0, rd); check("t1_rd2",     rd, 32'h0000_011C);
    wb(1'b0, 32'h1, 32'h0, rd); check("t1_status0", rd, 32'h0000_0100);
    check("t1_pending0", {31'b0, pending}, 32'h0);

    // Empty DATA read with STB held for 64 cycles
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    rises = 0; ack_lows = 0; prev_ack = ACK;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (ACK && !prev_ack) rises++;
      if (!ACK) ack_lows++;
      prev_ack = ACK;
    end
    check("t2_dato",     DAT_O,           32'h0);
    check("t2_ack_lows", 32'(ack_lows),   32'h0);
    check("t2_rises",    32'(rises),      32'h1);
    STB = 1'b0;
    tick();
    check("t2_ack_fall", {31'b0, ACK},    32'h0);
    wb(1'b0, 32'h1, 32'h0, rd); check("t2_status", rd, 32'h0000_0100);

    // Overflow: 17 pushes into a 16-entry FIFO
    for (int i = 1; i <= 17; i++) push(8'(i));
    wb(1'b0, 32'h1, 32'h0, rd); check("t3_status_ovf", rd, 32'h0000_0610);
    for (int i = 1; i <= 16; i++) begin
      wb(1'b0, 32'h0, 32'h0, rd);
      check($sformatf("t3_rd%0d", i), rd, 32'h100 + 32'(i));
    end
    wb(1'b0, 32'h1, 32'h0,   rd); check("t3_status_e", rd, 32'h0000_0500);
    wb(1'b1, 32'h1, 32'h400, rd);
    wb(1'b0, 32'h1, 32'h0,   rd); check("t3_ovf_clr",  rd, 32'h0000_0100);

    // Push while full concurrent with an accepted DATA read
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    ready_pulse = 1'b1; Keyboard_Data = 8'h55;
    tick();
    ready_pulse = 1'b0;
    check("t4_ack",  {31'b0, ACK}, 32'h1);
    check("t4_rd",   DAT_O,        32'h0000_0120);
    STB = 1'b0;
    tick();
    wb(1'b0, 32'h1, 32'h0, rd); check("t4_status", rd, 32'h0000_0210);
    for (int i = 1; i < 16; i++) begin
      wb(1'b0, 32'h0, 32'h0, rd);
      check($sformatf("t4_rd%0d", i), rd, 32'h120 + 32'(i));
    end
    wb(1'b0, 32'h0, 32'h0, rd); check("t4_last", rd, 32'h0000_0155);

    // Flush in the same cycle as a push
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    STB = 1'b1; WE = 1'b1; ADDR = 32'h1; DAT_I = 32'h1;
    ready_pulse = 1'b1; Keyboard_Data = 8'h77;
    tick();
    ready_pulse = 1'b0; STB = 1'b0; WE = 1'b0;
    tick();
    check("t5_pending", {31'b0, pending}, 32'h0);
    wb(1'b0, 32'h1, 32'h0, rd); check("t5_status", rd, 32'h0000_0100);
    wb(1'b0, 32'h0, 32'h0, rd); check("t5_rd",     rd, 32'h0000_0000);

    // Push while empty concurrent with a DATA read
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    ready_pulse = 1'b1; Keyboard_Data = 8'h3A;
    tick();
    ready_pulse = 1'b0;
    check("t7_rd_empty", DAT_O, 32'h0);
    STB = 1'b0;
    tick();
    wb(1'b0, 32'h1, 32'h0, rd); check("t7_status", rd, 32'h0000_0001);
    wb(1'b0, 32'h0, 32'h0, rd); check("t7_rd",     rd, 32'h0000_013A);

    // Reset in the middle of a transaction
    push(8'hA1); push(8'hA2); push(8'hA3);
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    tick();
    check("t6_ack_pre", {31'b0, ACK}, 32'h1);
    check("t6_rd_pre",  DAT_O,        32'h0000_01A1);
    reset = 1'b0;
    tick();
    check("t6_ack",     {31'b0, ACK},     32'h0);
    check("t6_dato",    DAT_O,            32'h0);
    check("t6_pending", {31'b0, pending}, 32'h0);
    STB = 1'b0; reset = 1'b1;
    tick();
    wb(1'b0, 32'h1, 32'h0, rd); check("t6_status", rd, 32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench never hangs
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
